// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared PHT counter encodings and update helper
package branch_predictor_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;
  localparam logic [1:0] BP_RESET_STATE = BP_WNT;

  // Next value of a 2-bit saturating counter given the resolved outcome.
  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == BP_ST) ? BP_ST : cnt + 2'b01;
    end
    return (cnt == BP_SNT) ? BP_SNT : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and EX resolution bundle for the predictor
interface branch_predictor_if;
  logic [31:0] i_if_pc;
  logic        o_predict_taken;
  logic [31:0] o_predict_target;
  logic        i_ex_branch;
  logic [31:0] i_ex_pc;
  logic        i_ex_taken;
  logic [31:0] i_ex_target;
  logic        i_ex_mispredicted;
  logic [31:0] o_branch_count;
  logic [31:0] o_mispredict_count;

  // Pipeline side: presents fetch PC and EX resolution, consumes predictions/stats.
  modport master (
    output i_if_pc, i_ex_branch, i_ex_pc, i_ex_taken, i_ex_target, i_ex_mispredicted,
    input  o_predict_taken, o_predict_target, o_branch_count, o_mispredict_count
  );

  // Predictor side.
  modport slave (
    input  i_if_pc, i_ex_branch, i_ex_pc, i_ex_taken, i_ex_target, i_ex_mispredicted,
    output o_predict_taken, o_predict_target, o_branch_count, o_mispredict_count
  );
endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB, combinational read, synchronous write
module branch_target_buffer #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_idx,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_hit,
  output logic [31:0]           rd_target,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_target
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  // Entry write on a taken resolution; an aliasing entry is simply overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = target_q[rd_idx];
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - PHT + BTB branch predictor with stats; BP_GSHARE_EN adds global history
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [INDEX_BITS-1:0] if_idx, ex_idx, if_pidx, ex_pidx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic [1:0]            pht_q [ENTRIES];
  logic                  btb_hit;
  logic [31:0]           btb_target;
  logic [31:0]           branch_cnt_q, mispredict_cnt_q;
  logic                  unused_pc_bits;

  assign if_idx = bp.i_if_pc[INDEX_BITS+1:2];
  assign if_tag = bp.i_if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign ex_idx = bp.i_ex_pc[INDEX_BITS+1:2];
  assign ex_tag = bp.i_ex_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  assign unused_pc_bits = ^{bp.i_if_pc[1:0], bp.i_if_pc[31:INDEX_BITS+TAG_BITS+2],
                            bp.i_ex_pc[1:0], bp.i_ex_pc[31:INDEX_BITS+TAG_BITS+2]};

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;

  // Committed global history: shifts in each resolved outcome.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (bp.i_ex_branch) begin
      ghr_q <= {ghr_q[INDEX_BITS-2:0], bp.i_ex_taken};
    end
  end

  assign if_pidx = if_idx ^ ghr_q;
  assign ex_pidx = ex_idx ^ ghr_q;
`else
  assign if_pidx = if_idx;
  assign ex_pidx = ex_idx;
`endif

  // PHT training from the EX resolution; lookups see the old value this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= BP_RESET_STATE;
      end
    end else if (bp.i_ex_branch) begin
      pht_q[ex_pidx] <= pht_next(pht_q[ex_pidx], bp.i_ex_taken);
    end
  end

  // Saturating resolution and misprediction counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (bp.i_ex_branch) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (bp.i_ex_mispredicted && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  branch_target_buffer #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_btb (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (if_idx),
    .rd_tag   (if_tag),
    .rd_hit   (btb_hit),
    .rd_target(btb_target),
    .wr_en    (bp.i_ex_branch && bp.i_ex_taken),
    .wr_idx   (ex_idx),
    .wr_tag   (ex_tag),
    .wr_target(bp.i_ex_target)
  );

  assign bp.o_predict_taken    = btb_hit && pht_q[if_pidx][1];
  assign bp.o_predict_target   = bp.o_predict_taken ? btb_target : 32'd0;
  assign bp.o_branch_count     = branch_cnt_q;
  assign bp.o_mispredict_count = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - vector table, directed corners and random checks against a reference model
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  branch_predictor_if bpi ();

  branch_predictor dut (
    .clk  (clk),
    .reset(reset),
    .bp   (bpi)
  );

  always #5 clk = ~clk;

  // Reference model: counters as plain integers 0..3, BTB as arrays, counts as wide ints.
  int          pht_m [64];
  bit          v_m   [64];
  int          tag_m [64];
  logic [31:0] tgt_m [64];
  longint      bc_m, mc_m;
  int          ghr_m;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3F);
  endfunction

  function automatic int mtag(input logic [31:0] pc);
    return int'((pc >> 8) & 32'hFF);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      pht_m[i] = 1;
      v_m[i]   = 1'b0;
      tag_m[i] = 0;
      tgt_m[i] = '0;
    end
    bc_m  = 0;
    mc_m  = 0;
    ghr_m = 0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i = midx(pc);
    int p = i ^ ghr_m;
    bit hit = v_m[i] && (tag_m[i] == mtag(pc));
    tk = hit && (pht_m[p] >= 2);
    tg = tk ? tgt_m[i] : 32'd0;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic tk,
                                       input logic [31:0] tg, input logic mis);
    int i = midx(pc);
    int p = i ^ ghr_m;
    if (tk) pht_m[p] = (pht_m[p] == 3) ? 3 : pht_m[p] + 1;
    else    pht_m[p] = (pht_m[p] == 0) ? 0 : pht_m[p] - 1;
    if (tk) begin
      v_m[i]   = 1'b1;
      tag_m[i] = mtag(pc);
      tgt_m[i] = tg;
    end
    if (bc_m < 64'hFFFF_FFFF) bc_m++;
    if (mis && mc_m < 64'hFFFF_FFFF) mc_m++;
`ifdef BP_GSHARE_EN
    ghr_m = ((ghr_m << 1) | int'(tk)) & 63;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bpi.i_ex_branch = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Present one resolution (or none) for one edge, tracking it in the model.
  task automatic drive_update(input logic br, input logic [31:0] pc, input logic tk,
                              input logic [31:0] tg, input logic mis);
    bpi.i_ex_branch       = br;
    bpi.i_ex_pc           = pc;
    bpi.i_ex_taken        = tk;
    bpi.i_ex_target       = tg;
    bpi.i_ex_mispredicted = mis;
    @(posedge clk);
    if (br) model_update(pc, tk, tg, mis);
    #1;
    bpi.i_ex_branch = 1'b0;
  endtask

  typedef struct {
    logic        br;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] lpc;
    logic        exp_tk;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs [8];

  logic        m_tk;
  logic [31:0] m_tg;
  logic [31:0] rpc, rex;
  logic        rbr, rtk, rmis;

  initial begin
    vecs[0] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h40,   1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h40,   1'b1, 32'h80,  1'b1, 32'h40,   1'b1, 32'h80};
    vecs[2] = '{1'b1, 32'h40,   1'b1, 32'h80,  1'b0, 32'h40,   1'b1, 32'h80};
    vecs[3] = '{1'b1, 32'h40,   1'b0, 32'h0,   1'b0, 32'h40,   1'b1, 32'h80};
    vecs[4] = '{1'b1, 32'h40,   1'b0, 32'h0,   1'b1, 32'h40,   1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h40,   1'b1, 32'h80,  1'b0, 32'h40,   1'b1, 32'h80};
    vecs[6] = '{1'b1, 32'h4040, 1'b1, 32'h100, 1'b0, 32'h4040, 1'b1, 32'h100};
    vecs[7] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h40,   1'b0, 32'h0};

    bpi.i_if_pc = 32'h0;
    bpi.i_ex_branch = 1'b0;
    bpi.i_ex_pc = 32'h0;
    bpi.i_ex_taken = 1'b0;
    bpi.i_ex_target = 32'h0;
    bpi.i_ex_mispredicted = 1'b0;

    // Reset state.
    do_reset();
    bpi.i_if_pc = 32'h1234;
    #2;
    check("reset_taken", {31'd0, bpi.o_predict_taken}, 32'd0);
    check("reset_target", bpi.o_predict_target, 32'd0);
    check("reset_bcount", bpi.o_branch_count, 32'd0);
    check("reset_mcount", bpi.o_mispredict_count, 32'd0);

`ifndef BP_GSHARE_EN
    // Training, hysteresis and aliasing from the vector table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_update(vecs[i].br, vecs[i].pc, vecs[i].tk, vecs[i].tgt, vecs[i].mis);
      bpi.i_if_pc = vecs[i].lpc;
      #2;
      check($sformatf("vec%0d_taken", i), {31'd0, bpi.o_predict_taken}, {31'd0, vecs[i].exp_tk});
      check($sformatf("vec%0d_target", i), bpi.o_predict_target, vecs[i].exp_tgt);
    end
    check("vec_bcount", bpi.o_branch_count, 32'd6);
    check("vec_mcount", bpi.o_mispredict_count, 32'd2);
`endif

    // Same-cycle lookup and update: old prediction now, new one next cycle.
    do_reset();
    drive_update(1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
    bpi.i_if_pc = 32'h200;
    bpi.i_ex_branch = 1'b1;
    bpi.i_ex_pc = 32'h200;
    bpi.i_ex_taken = 1'b1;
    bpi.i_ex_target = 32'h300;
    bpi.i_ex_mispredicted = 1'b0;
    #2;
    model_predict(32'h200, m_tk, m_tg);
    check("collide_old_taken", {31'd0, bpi.o_predict_taken}, {31'd0, m_tk});
    check("collide_old_target", bpi.o_predict_target, m_tg);
    @(posedge clk);
    model_update(32'h200, 1'b1, 32'h300, 1'b0);
    #1;
    bpi.i_ex_branch = 1'b0;
    #2;
    model_predict(32'h200, m_tk, m_tg);
    check("collide_new_taken", {31'd0, bpi.o_predict_taken}, {31'd0, m_tk});
    check("collide_new_target", bpi.o_predict_target, m_tg);
    check("collide_new_is_taken", {31'd0, bpi.o_predict_taken}, 32'd1);

    // Reset wins over a simultaneous update.
    reset = 1'b1;
    bpi.i_ex_branch = 1'b1;
    bpi.i_ex_pc = 32'h40;
    bpi.i_ex_taken = 1'b1;
    bpi.i_ex_target = 32'h80;
    bpi.i_ex_mispredicted = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bpi.i_ex_branch = 1'b0;
    model_reset();
    bpi.i_if_pc = 32'h200;
    #2;
    check("rstprio_bcount", bpi.o_branch_count, 32'd0);
    check("rstprio_mcount", bpi.o_mispredict_count, 32'd0);
    check("rstprio_taken", {31'd0, bpi.o_predict_taken}, 32'd0);

    // Statistics: five resolutions, two mispredicted.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_update(1'b1, 32'h100 + 32'(i * 4), i[0], 32'h500, (i == 1 || i == 3));
    end
    drive_update(1'b0, 32'h100, 1'b1, 32'h500, 1'b1);
    check("stats_bcount", bpi.o_branch_count, 32'd5);
    check("stats_mcount", bpi.o_mispredict_count, 32'd2);

    // Saturation at all-ones.
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    release dut.mispredict_cnt_q;
    drive_update(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    #1;
    check("sat_bcount", bpi.o_branch_count, 32'hFFFF_FFFF);
    check("sat_mcount", bpi.o_mispredict_count, 32'hFFFF_FFFF);

`ifdef BP_GSHARE_EN
    do_reset();
    drive_update(1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
    drive_update(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    drive_update(1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
    check("ghr_tnt", {29'd0, dut.ghr_q[2:0]}, 32'd5);
`endif

    // Random traffic over a small PC pool so entries are hit, aliased and retrained.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rpc  = ($urandom() & 32'hFFFF_0003) | (32'($urandom_range(0, 1)) << 8) | (32'($urandom_range(0, 7)) << 2);
      rex  = ($urandom() & 32'hFFFF_0003) | (32'($urandom_range(0, 1)) << 8) | (32'($urandom_range(0, 7)) << 2);
      rbr  = ($urandom_range(0, 3) != 0);
      rtk  = $urandom_range(0, 1) == 1;
      rmis = ($urandom_range(0, 3) == 0);
      bpi.i_if_pc = rpc;
      bpi.i_ex_branch = rbr;
      bpi.i_ex_pc = rex;
      bpi.i_ex_taken = rtk;
      bpi.i_ex_target = $urandom() & 32'hFFFF_FFFC;
      bpi.i_ex_mispredicted = rmis;
      #3;
      model_predict(rpc, m_tk, m_tg);
      check("rand_taken", {31'd0, bpi.o_predict_taken}, {31'd0, m_tk});
      check("rand_target", bpi.o_predict_target, m_tg);
      check("rand_bcount", bpi.o_branch_count, bc_m[31:0]);
      check("rand_mcount", bpi.o_mispredict_count, mc_m[31:0]);
      @(posedge clk);
      if (rbr) model_update(rex, rtk, bpi.i_ex_target, rmis);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
